// File: rtl/string_gen_varlen_if.sv
// ---------------------------------------------------------------------------
// string_gen_varlen_if
// Candidate stream from the brute-force generator to the hash core.
//   out_str   : candidate characters, position 0 in the MSBs, unused positions 0
//   out_len   : number of valid character positions in out_str
//   out_valid : candidate is being presented
//   out_ready : consumer accepts the presented candidate
// master = generator side, slave = consumer side.
// ---------------------------------------------------------------------------
interface string_gen_varlen_if #(
  parameter int MAX_LEN = 8,
  parameter int CHAR_W  = 7,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic [MAX_LEN*CHAR_W-1:0] out_str;
  logic [LEN_W-1:0]          out_len;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output out_str,
    output out_len,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_str,
    input  out_len,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/string_gen_varlen.sv
// ---------------------------------------------------------------------------
// string_gen_varlen
// Enumerates every string of length min_len..max_len over a per-position
// charset and streams them to the hash core with valid/ready.
// Ports:
//   clk, reset_n           : clock, synchronous active-low reset
//   start, abort           : launch (IDLE/DONE only) / stop (RUN only)
//   min_len, max_len       : length range, sampled on start
//   cs_clear, cs_wr_en,
//   cs_wr_pos, cs_wr_char  : charset load port (ignored while busy)
//   out_if                 : candidate stream (master side)
//   busy, done, err        : RUN state, finished (sticky), config error
//   cand_count             : handshakes since last start (wraps)
// ---------------------------------------------------------------------------
module string_gen_varlen #(
  parameter int MAX_LEN  = 8,
  parameter int CHAR_W   = 7,
  parameter int CS_DEPTH = 64,
  parameter int IDX_W    = $clog2(CS_DEPTH),
  parameter int LEN_W    = $clog2(MAX_LEN + 1),
  parameter int CNT_W    = 48,
  parameter int POS_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_W-1:0]     min_len,
  input  logic [LEN_W-1:0]     max_len,
  input  logic                 cs_clear,
  input  logic                 cs_wr_en,
  input  logic [POS_W-1:0]     cs_wr_pos,
  input  logic [CHAR_W-1:0]    cs_wr_char,
  string_gen_varlen_if.master  out_if,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     cand_count
);

  // Charset lengths need one extra bit to represent a full charset.
  localparam int LW = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [MAX_LEN-1:0][IDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]                cur_len_q, cur_len_d;
  logic [LEN_W-1:0]                max_len_q, max_len_d;
  logic                            out_valid_q, out_valid_d;
  logic [MAX_LEN*CHAR_W-1:0]       out_str_q, out_str_d;
  logic [LEN_W-1:0]                out_len_q, out_len_d;
  logic                            done_q, done_d;
  logic                            err_q, err_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  logic [MAX_LEN-1:0][LW-1:0]      cs_len_q;
  logic [CHAR_W-1:0]               mem_q [MAX_LEN][CS_DEPTH];

  logic                            hs_s;
  logic                            cfg_err_s;
  logic                            wr_ok_s;
  logic [MAX_LEN-1:0][IDX_W-1:0]   inc_idx_s;
  logic                            carry_out_s;
  logic                            load_str_s;
  logic                            clear_str_s;
  logic [MAX_LEN*CHAR_W-1:0]       cand_str_s;

  assign hs_s = out_valid_q & out_if.out_ready;

  // Charset append is accepted only outside RUN, without a clear, and while not full.
  assign wr_ok_s = (state_q != S_RUN) && !cs_clear && cs_wr_en &&
                   (cs_len_q[cs_wr_pos] != LW'(CS_DEPTH));

  // Charset length bookkeeping; clear wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_len_q <= {(MAX_LEN*LW){1'b0}};
    end else if (state_q != S_RUN && cs_clear) begin
      cs_len_q <= {(MAX_LEN*LW){1'b0}};
    end else if (wr_ok_s) begin
      cs_len_q[cs_wr_pos] <= cs_len_q[cs_wr_pos] + {{(LW-1){1'b0}}, 1'b1};
    end
  end

  // Charset storage; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (reset_n && wr_ok_s) begin
      mem_q[cs_wr_pos][cs_len_q[cs_wr_pos][IDX_W-1:0]] <= cs_wr_char;
    end
  end

  // Configuration check on the live inputs, evaluated in the start cycle.
  always_comb begin
    cfg_err_s = 1'b0;
    if ((min_len == {LEN_W{1'b0}}) || (min_len > max_len) || (max_len > LEN_W'(MAX_LEN))) begin
      cfg_err_s = 1'b1;
    end else begin
      cfg_err_s = 1'b0;
    end
    for (int p = 0; p < MAX_LEN; p++) begin
      if ((LEN_W'(p) < max_len) && (cs_len_q[p] == {LW{1'b0}})) begin
        cfg_err_s = 1'b1;
      end else begin
      end
    end
  end

  // Mixed-radix increment over digits 0..L-1; idx[0] is the fastest digit.
  always_comb begin
    logic c;
    c         = 1'b1;
    inc_idx_s = idx_q;
    for (int p = 0; p < MAX_LEN; p++) begin
      if ((LEN_W'(p) < cur_len_q) && c) begin
        if (({1'b0, idx_q[p]} + {{(LW-1){1'b0}}, 1'b1}) == cs_len_q[p]) begin
          inc_idx_s[p] = {IDX_W{1'b0}};
        end else begin
          inc_idx_s[p] = idx_q[p] + {{(IDX_W-1){1'b0}}, 1'b1};
          c            = 1'b0;
        end
      end else begin
        inc_idx_s[p] = idx_q[p];
      end
    end
    carry_out_s = c;
  end

  // Next-state and output logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_len_d   = cur_len_q;
    max_len_d   = max_len_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    load_str_s  = 1'b0;
    clear_str_s = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          max_len_d = max_len;
          cnt_d     = {CNT_W{1'b0}};
          idx_d     = {(MAX_LEN*IDX_W){1'b0}};
          cur_len_d = min_len;
          if (cfg_err_s) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            err_d       = 1'b1;
            out_valid_d = 1'b0;
            clear_str_s = 1'b1;
          end else begin
            state_d     = S_RUN;
            done_d      = 1'b0;
            err_d       = 1'b0;
            out_valid_d = 1'b1;
            load_str_s  = 1'b1;
          end
        end else begin
        end
      end
      S_RUN: begin
        if (hs_s) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
        end
        if (abort) begin
          // A same-cycle handshake is counted above, but nothing further is shown.
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          done_d      = 1'b0;
          clear_str_s = 1'b1;
        end else if (hs_s) begin
          idx_d = inc_idx_s;
          if (carry_out_s && (cur_len_q == max_len_q)) begin
            state_d     = S_DONE;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            err_d       = 1'b0;
            clear_str_s = 1'b1;
          end else if (carry_out_s) begin
            // All digits wrapped to 0 already; grow the candidate by one position.
            cur_len_d  = cur_len_q + {{(LEN_W-1){1'b0}}, 1'b1};
            load_str_s = 1'b1;
          end else begin
            load_str_s = 1'b1;
          end
        end else begin
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        clear_str_s = 1'b1;
      end
    endcase

    // Candidate built from the next indices so the output register is ready a cycle later.
    cand_str_s = {(MAX_LEN*CHAR_W){1'b0}};
    for (int p = 0; p < MAX_LEN; p++) begin
      if (LEN_W'(p) < cur_len_d) begin
        cand_str_s[(MAX_LEN-1-p)*CHAR_W +: CHAR_W] = mem_q[p][idx_d[p]];
      end else begin
        cand_str_s[(MAX_LEN-1-p)*CHAR_W +: CHAR_W] = {CHAR_W{1'b0}};
      end
    end

    if (load_str_s) begin
      out_str_d = cand_str_s;
      out_len_d = cur_len_d;
    end else if (clear_str_s) begin
      out_str_d = {(MAX_LEN*CHAR_W){1'b0}};
      out_len_d = {LEN_W{1'b0}};
    end else begin
      out_str_d = out_str_q;
      out_len_d = out_len_q;
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= {(MAX_LEN*IDX_W){1'b0}};
      cur_len_q   <= {LEN_W{1'b0}};
      max_len_q   <= {LEN_W{1'b0}};
      out_valid_q <= 1'b0;
      out_str_q   <= {(MAX_LEN*CHAR_W){1'b0}};
      out_len_q   <= {LEN_W{1'b0}};
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_len_q   <= cur_len_d;
      max_len_q   <= max_len_d;
      out_valid_q <= out_valid_d;
      out_str_q   <= out_str_d;
      out_len_q   <= out_len_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_if.out_str   = out_str_q;
  assign out_if.out_len   = out_len_q;
  assign out_if.out_valid = out_valid_q;
  assign busy             = (state_q == S_RUN);
  assign done             = done_q;
  assign err              = err_q;
  assign cand_count       = cnt_q;

endmodule

// File: tb/tb_string_gen_varlen.sv
module tb_string_gen_varlen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [3:0]  min_len;
  logic [3:0]  max_len;
  logic        cs_clear;
  logic        cs_wr_en;
  logic [2:0]  cs_wr_pos;
  logic [6:0]  cs_wr_char;
  logic        busy;
  logic        done;
  logic        err;
  logic [47:0] cand_count;

  int passed = 0;
  int total  = 0;

  logic [55:0] std_str [6];
  logic [3:0]  std_len [6];

  string_gen_varlen_if #(.MAX_LEN(8), .CHAR_W(7), .LEN_W(4)) bus ();

  string_gen_varlen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .min_len    (min_len),
    .max_len    (max_len),
    .cs_clear   (cs_clear),
    .cs_wr_en   (cs_wr_en),
    .cs_wr_pos  (cs_wr_pos),
    .cs_wr_char (cs_wr_char),
    .out_if     (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cand_count (cand_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [55:0] mk2(input logic [6:0] c0, input logic [6:0] c1);
    return {c0, c1, 42'd0};
  endfunction

  task automatic cs_write(input int pos, input logic [6:0] ch);
    cs_wr_pos  = 3'(pos);
    cs_wr_char = ch;
    cs_wr_en   = 1'b1;
    @(negedge clk);
    cs_wr_en   = 1'b0;
  endtask

  task automatic cs_do_clear();
    cs_clear = 1'b1;
    @(negedge clk);
    cs_clear = 1'b0;
  endtask

  task automatic load_std();
    cs_do_clear();
    cs_write(0, 7'h61);
    cs_write(0, 7'h62);
    cs_write(1, 7'h78);
    cs_write(1, 7'h79);
  endtask

  // Returns on the negedge after the start edge: the first result is visible.
  task automatic start_run(input logic [3:0] mn, input logic [3:0] mx);
    min_len = mn;
    max_len = mx;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    total++;
    if ({bus.out_valid, busy, done, err} !== 4'b0000) $display("FAIL reset_flags: got %b exp 0000", {bus.out_valid, busy, done, err});
    else passed++;
    total++;
    if (cand_count !== 48'd0) $display("FAIL reset_count: got %0d exp 0", cand_count);
    else passed++;
    total++;
    if ({bus.out_len, bus.out_str} !== 60'd0) $display("FAIL reset_out: got len %0d str %h exp 0", bus.out_len, bus.out_str);
    else passed++;
  endtask

  task automatic test_basic();
    load_std();
    bus.out_ready = 1'b1;
    start_run(4'd1, 4'd2);
    for (int k = 0; k < 6; k++) begin
      total++;
      if ({bus.out_valid, bus.out_len, bus.out_str} !== {1'b1, std_len[k], std_str[k]})
        $display("FAIL basic_cand%0d: got v%b len %0d str %h exp len %0d str %h", k, bus.out_valid, bus.out_len, bus.out_str, std_len[k], std_str[k]);
      else passed++;
      @(negedge clk);
    end
    total++;
    if ({bus.out_valid, busy, done, err} !== 4'b0010) $display("FAIL basic_end_flags: got %b exp 0010", {bus.out_valid, busy, done, err});
    else passed++;
    total++;
    if (cand_count !== 48'd6) $display("FAIL basic_count: got %0d exp 6", cand_count);
    else passed++;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b1;
    start_run(4'd1, 4'd2);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          total++;
          if ({bus.out_valid, bus.out_len, bus.out_str, cand_count} !== {1'b1, 4'd2, mk2(7'h61, 7'h78), 48'd2})
            $display("FAIL stall%0d: got v%b len %0d str %h cnt %0d exp ax len 2 cnt 2", s, bus.out_valid, bus.out_len, bus.out_str, cand_count);
          else passed++;
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
      total++;
      if ({bus.out_valid, bus.out_len, bus.out_str} !== {1'b1, std_len[k], std_str[k]})
        $display("FAIL bp_cand%0d: got v%b len %0d str %h exp len %0d str %h", k, bus.out_valid, bus.out_len, bus.out_str, std_len[k], std_str[k]);
      else passed++;
      @(negedge clk);
    end
    total++;
    if ({done, cand_count} !== {1'b1, 48'd6}) $display("FAIL bp_end: got done %b cnt %0d exp 1 6", done, cand_count);
    else passed++;
  endtask

  task automatic test_cfg_err();
    start_run(4'd3, 4'd2);
    total++;
    if ({bus.out_valid, busy, done, err} !== 4'b0011) $display("FAIL cfg_minmax: got %b exp 0011", {bus.out_valid, busy, done, err});
    else passed++;
    start_run(4'd1, 4'd9);
    total++;
    if ({bus.out_valid, done, err} !== 3'b011) $display("FAIL cfg_maxlen: got %b exp 011", {bus.out_valid, done, err});
    else passed++;
    cs_do_clear();
    cs_write(0, 7'h61);
    start_run(4'd1, 4'd2);
    total++;
    if ({bus.out_valid, busy, done, err} !== 4'b0011) $display("FAIL cfg_empty_pos1: got %b exp 0011", {bus.out_valid, busy, done, err});
    else passed++;
    start_run(4'd1, 4'd1);
    total++;
    if ({bus.out_valid, err, bus.out_str} !== {1'b1, 1'b0, 7'h61, 49'd0}) $display("FAIL cfg_ok_len1: got v%b err %b str %h", bus.out_valid, err, bus.out_str);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    load_std();
    bus.out_ready = 1'b1;
    start_run(4'd1, 4'd2);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus.out_str !== std_str[k]) $display("FAIL abort_cand%0d: got %h exp %h", k, bus.out_str, std_str[k]);
      else passed++;
      if (k == 2) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    total++;
    if ({bus.out_valid, busy, done, cand_count} !== {3'b000, 48'd3}) $display("FAIL abort_state: got v%b busy %b done %b cnt %0d exp 0 0 0 3", bus.out_valid, busy, done, cand_count);
    else passed++;
    start_run(4'd1, 4'd2);
    total++;
    if ({bus.out_valid, bus.out_len, bus.out_str, cand_count} !== {1'b1, 4'd1, std_str[0], 48'd0})
      $display("FAIL abort_restart: got v%b len %0d str %h cnt %0d exp a len 1 cnt 0", bus.out_valid, bus.out_len, bus.out_str, cand_count);
    else passed++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_overflow();
    logic [55:0] exp_s;
    cs_do_clear();
    for (int i = 0; i < 64; i++) cs_write(0, 7'(i + 16));
    cs_write(0, 7'h7f);
    bus.out_ready = 1'b1;
    start_run(4'd1, 4'd1);
    for (int k = 0; k < 64; k++) begin
      if (k == 10) cs_clear = 1'b1;
      if (k == 20) begin
        cs_wr_pos = 3'd1; cs_wr_char = 7'h7f; cs_wr_en = 1'b1;
      end
      exp_s = {7'(k + 16), 49'd0};
      total++;
      if ({bus.out_valid, bus.out_str} !== {1'b1, exp_s}) $display("FAIL ovf_cand%0d: got v%b str %h exp %h", k, bus.out_valid, bus.out_str, exp_s);
      else passed++;
      @(negedge clk);
      cs_clear = 1'b0;
      cs_wr_en = 1'b0;
    end
    total++;
    if ({bus.out_valid, done, cand_count} !== {2'b01, 48'd64}) $display("FAIL ovf_end: got v%b done %b cnt %0d exp 0 1 64", bus.out_valid, done, cand_count);
    else passed++;
    start_run(4'd1, 4'd2);
    total++;
    if ({done, err} !== 2'b11) $display("FAIL ovf_run_write_ignored: got %b exp 11", {done, err});
    else passed++;
  endtask

  task automatic test_reset_midrun();
    load_std();
    bus.out_ready = 1'b1;
    start_run(4'd1, 4'd2);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.out_valid, busy, done, err, cand_count, bus.out_len, bus.out_str} !== 112'd0)
      $display("FAIL midrun_reset: got v%b b%b d%b e%b cnt %0d len %0d str %h exp all 0", bus.out_valid, busy, done, err, cand_count, bus.out_len, bus.out_str);
    else passed++;
    reset_n = 1'b1;
    start_run(4'd1, 4'd2);
    total++;
    if ({bus.out_valid, done, err} !== 3'b011) $display("FAIL midrun_empty_cs: got %b exp 011", {bus.out_valid, done, err});
    else passed++;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    min_len = 4'd0; max_len = 4'd0;
    cs_clear = 1'b0; cs_wr_en = 1'b0; cs_wr_pos = 3'd0; cs_wr_char = 7'd0;
    bus.out_ready = 1'b0;
    std_str[0] = {7'h61, 49'd0};        std_len[0] = 4'd1;
    std_str[1] = {7'h62, 49'd0};        std_len[1] = 4'd1;
    std_str[2] = mk2(7'h61, 7'h78);     std_len[2] = 4'd2;
    std_str[3] = mk2(7'h62, 7'h78);     std_len[3] = 4'd2;
    std_str[4] = mk2(7'h61, 7'h79);     std_len[4] = 4'd2;
    std_str[5] = mk2(7'h62, 7'h79);     std_len[5] = 4'd2;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_cfg_err();
    test_abort();
    test_overflow();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
